// File: rtl/switch_mcu_fetch.sv
// switch_mcu_fetch: instruction fetch stage; owns the PC, issues imem word reads,
// buffers in-order responses and hands {inst, pc} to the decoder over valid/ready.
//
// Ports:
//   input_clk, input_rst_n                     clock, async active-low reset
//   output_imem_req_valid/addr, input_imem_req_ready   fetch request channel
//   input_imem_rsp_valid/data                  in-order read data, never stalled
//   input_redirect_valid/pc                    one-cycle redirect from execute
//   output_inst_valid/inst/inst_pc, input_inst_ready   decoder handshake
module switch_mcu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        input_clk,
    input  logic        input_rst_n,
    output logic        output_imem_req_valid,
    input  logic        input_imem_req_ready,
    output logic [31:0] output_imem_req_addr,
    input  logic        input_imem_rsp_valid,
    input  logic [31:0] input_imem_rsp_data,
    input  logic        input_redirect_valid,
    input  logic [31:0] input_redirect_pc,
    output logic        output_inst_valid,
    input  logic        input_inst_ready,
    output logic [31:0] output_inst,
    output logic [31:0] output_inst_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   pcq       [FIFO_DEPTH];

    logic          req_hs;
    logic          rsp_drop;
    logic          rsp_take;
    logic          pop;
    logic [CW:0]   in_use;
    logic [CW:0]   redir_discard;
    logic          unused_rpc_lsb;

    assign unused_rpc_lsb = ^input_redirect_pc[1:0];

    always_comb begin
        in_use                = {1'b0, fifo_count} + {1'b0, outstanding};
        output_imem_req_valid = (state == RUN) && (in_use < DEPTH_W);
        output_imem_req_addr  = pc;
        output_inst_valid     = (fifo_count != '0);
        output_inst           = fifo_inst[fifo_rd];
        output_inst_pc        = fifo_pc[fifo_rd];
        req_hs   = output_imem_req_valid && input_imem_req_ready;
        rsp_drop = input_imem_rsp_valid && (discard != '0);
        rsp_take = input_imem_rsp_valid && (discard == '0)
                   && (outstanding != '0);
        pop      = output_inst_valid && input_inst_ready;
        // Every word still owed by imem becomes stale; a response
        // consumed this cycle (dropped or taken) is no longer owed.
        redir_discard = {1'b0, discard} + {1'b0, outstanding}
                      + (CW+1)'(req_hs)
                      - (CW+1)'(rsp_drop | rsp_take);
    end

    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
                pcq[i]       <= '0;
            end
        end else if (input_redirect_valid) begin
            pc          <= {input_redirect_pc[31:2], 2'b00};
            outstanding <= '0;
            discard     <= redir_discard[CW-1:0];
            state       <= (redir_discard != '0) ? FLUSH : RUN;
            fifo_count  <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            unique case (state)
                BOOT:    state <= RUN;
                RUN:     state <= RUN;
                FLUSH:   if (discard == CW'(rsp_drop)) state <= RUN;
                default: state <= BOOT;
            endcase
            if (req_hs) begin
                pc          <= pc + 32'd4;
                pcq[pcq_wr] <= pc;
                pcq_wr      <= pcq_wr + AW'(1);
            end
            if (rsp_take) begin
                fifo_inst[fifo_wr] <= input_imem_rsp_data;
                fifo_pc[fifo_wr]   <= pcq[pcq_rd];
                fifo_wr            <= fifo_wr + AW'(1);
                pcq_rd             <= pcq_rd + AW'(1);
            end
            if (pop) fifo_rd <= fifo_rd + AW'(1);
            fifo_count  <= fifo_count + CW'(rsp_take) - CW'(pop);
            outstanding <= outstanding + CW'(req_hs) - CW'(rsp_take);
            discard     <= discard - CW'(rsp_drop);
        end
    end

endmodule

// File: tb/tb_switch_mcu_fetch.sv
// tb_switch_mcu_fetch: directed bench for switch_mcu_fetch with an in-order
// imem model and a scoreboard that checks every word the decoder accepts.
module tb_switch_mcu_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int          vectors = 0;
    int          miscompares = 0;
    int          delivered = 0;
    logic        rsp_en = 1'b1;
    logic [31:0] exp_q[$];
    logic [31:0] pend[$];
    logic [31:0] req_log[$];
    logic [31:0] mon_e;

    always #5 clk = ~clk;

    switch_mcu_fetch #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .input_clk            (clk),
        .input_rst_n          (rst_n),
        .output_imem_req_valid(req_valid),
        .input_imem_req_ready (req_ready),
        .output_imem_req_addr (req_addr),
        .input_imem_rsp_valid (rsp_valid),
        .input_imem_rsp_data  (rsp_data),
        .input_redirect_valid (redir_valid),
        .input_redirect_pc    (redir_pc),
        .output_inst_valid    (inst_valid),
        .input_inst_ready     (inst_ready),
        .output_inst          (inst),
        .output_inst_pc       (inst_pc)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    // imem: logs accepted requests, answers one per cycle in order
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && req_valid && req_ready) begin
                pend.push_back(req_addr);
                req_log.push_back(req_addr);
            end
            @(posedge clk);
            #1;
            if (rsp_en && pend.size() > 0) begin
                rsp_valid = 1'b1;
                rsp_data  = memw(pend.pop_front());
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = '0;
            end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready && !redir_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_inst: got pc %h want none", inst_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("inst_pc", inst_pc, mon_e);
                check("inst", inst, memw(mon_e));
                delivered++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_run(input logic [31:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_deliv(input int n, input string nm);
        int t;
        t = 0;
        while (delivered < n && t < 200) begin
            step(1);
            t++;
        end
        check(nm, 32'(delivered >= n), 32'd1);
    endtask

    task automatic wait_pend2();
        int t;
        t = 0;
        while (pend.size() < 2 && t < 50) begin
            step(1);
            t++;
        end
        check("two_outstanding", 32'(pend.size()), 32'd2);
    endtask

    task automatic log_at(input string nm, input int idx,
                          input logic [31:0] expv);
        logic [31:0] a;
        a = (idx < req_log.size()) ? req_log[idx] : 32'hxxxx_xxxx;
        check(nm, a, expv);
    endtask

    task automatic redirect(input logic [31:0] pc, input logic [31:0] base);
        redir_valid = 1'b1;
        redir_pc    = pc;
        push_run(base, 64);
        step(1);
        redir_valid = 1'b0;
        req_log.delete();
    endtask

    task automatic settle_full();
        inst_ready = 1'b0;
        step(10);
    endtask

    initial begin
        int t;
        int d0;
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int d0;
        push_run(32'h0, 64);
        step(3);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);

        // basic stream and first-valid latency
        rst_n = 1'b1;
        t = 0;
        while (!inst_valid && t < 20) begin
            step(1);
            t++;
        end
        check("first_valid_cycle", 32'(t), 32'd3);
        wait_deliv(4, "stream_0_to_12");

        // decoder stall from a fresh pipe
        settle_full();
        redirect(32'h0000_0200, 32'h0000_0200);
        step(10);
        check("stall_req_count", 32'(req_log.size()), 32'd2);
        check("stall_req_valid", 32'(req_valid), 32'd0);
        log_at("stall_req0", 0, 32'h0000_0200);
        log_at("stall_req1", 1, 32'h0000_0204);
        d0 = delivered;
        inst_ready = 1'b1;
        wait_deliv(d0 + 6, "stall_resume");

        // redirect with two responses outstanding
        settle_full();
        rsp_en = 1'b0;
        inst_ready = 1'b1;
        wait_pend2();
        redirect(32'h0000_0103, 32'h0000_0100);
        step(3);
        check("flush_hold", 32'(req_valid), 32'd0);
        check("flush_no_req", 32'(req_log.size()), 32'd0);
        rsp_en = 1'b1;
        d0 = delivered;
        wait_deliv(d0 + 4, "after_redirect_100");
        log_at("redir_addr", 0, 32'h0000_0100);

        // redirect coinciding with a response and a request handshake
        t = 0;
        while (!(rsp_valid && req_valid && req_ready) && t < 20) begin
            step(1);
            t++;
        end
        check("rsp_req_same_cycle", 32'(rsp_valid && req_valid), 32'd1);
        redirect(32'h0000_0400, 32'h0000_0400);
        check("fifo_empty_after_redir", 32'(inst_valid), 32'd0);
        d0 = delivered;
        wait_deliv(d0 + 4, "after_redirect_400");

        // PC wrap
        redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        d0 = delivered;
        wait_deliv(d0 + 4, "wrap_stream");
        log_at("wrap_addr0", 0, 32'hFFFF_FFFC);
        log_at("wrap_addr1", 1, 32'h0000_0000);

        // reset with two responses outstanding
        settle_full();
        rsp_en = 1'b0;
        inst_ready = 1'b1;
        wait_pend2();
        rst_n = 1'b0;
        #1;
        check("async_req_valid", 32'(req_valid), 32'd0);
        check("async_inst_valid", 32'(inst_valid), 32'd0);
        check("async_inst", inst, 32'd0);
        check("async_inst_pc", inst_pc, 32'd0);
        push_run(32'h0, 64);
        step(1);
        rsp_en = 1'b1;
        step(1);
        rst_n = 1'b1;
        req_log.delete();
        d0 = delivered;
        wait_deliv(d0 + 4, "restart_stream");
        log_at("restart_addr", 0, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
